// File: rtl/usb_rx_word_fifo.sv
// usb_rx_word_fifo: packs received USB bytes into BYTES_PER_WORD-byte words and queues
// them, each tagged with its valid byte count, in a DEPTH-entry show-ahead FIFO.
// A partial word is flushed at end of packet. Overflow is sticky. buff_clear is a
// synchronous clear.
// Build option: define USB_RX_BYTE_SWAP_EN for big-endian packing, where the first byte
// goes to the most significant byte and a partial word is left-aligned.
module usb_rx_word_fifo #(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned DEPTH          = 4
) (
  input  logic                                   clk,
  input  logic                                   n_rst,
  input  logic                                   byte_received,
  input  logic                                   data_en,
  input  logic [7:0]                             data,
  input  logic                                   eop,
  input  logic                                   buff_clear,
  input  logic                                   rd_en,
  output logic [8*BYTES_PER_WORD-1:0]            rd_data,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]    rd_bytes,
  output logic                                   word_valid,
  output logic                                   buff_full,
  output logic [$clog2(DEPTH+1)-1:0]             word_count,
  output logic                                   overflow
);

  localparam int unsigned DataW = 8 * BYTES_PER_WORD;
  localparam int unsigned CntW  = $clog2(BYTES_PER_WORD + 1);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned WcW   = $clog2(DEPTH + 1);

  logic [DataW-1:0] asm_q, asm_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [WcW-1:0]   count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [DataW-1:0] mem_data_q  [DEPTH];
  logic [CntW-1:0]  mem_bytes_q [DEPTH];

  logic             accept;
  logic [DataW-1:0] asm_word;
  logic [CntW-1:0]  push_bytes;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             mem_we;

  // Merge the incoming byte into the assembler and decide whether a word completes.
  always_comb begin
    accept   = byte_received & data_en;
    asm_word = asm_q;
    for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
      if (accept && cnt_q == CntW'(k)) begin
`ifdef USB_RX_BYTE_SWAP_EN
        asm_word[8*(int'(BYTES_PER_WORD)-1-k) +: 8] = data;
`else
        asm_word[8*k +: 8] = data;
`endif
      end
    end
    push_bytes = cnt_q + CntW'(accept);
    // A byte accepted alongside eop is part of the flushed word.
    push = (accept && cnt_q == CntW'(BYTES_PER_WORD - 1)) || (eop && push_bytes != '0);
  end

  // Next-state for assembler, pointers, occupancy and overflow; clear wins over everything.
  always_comb begin
    full       = (count_q == WcW'(DEPTH));
    pop        = rd_en && (count_q != '0);
    // A push into a full FIFO is only kept if a pop frees the head slot this cycle.
    wr_en      = push && (!full || pop);
    mem_we     = 1'b0;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (buff_clear) begin
      asm_d      = '0;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      mem_we     = wr_en;
      asm_d      = push ? '0 : asm_word;
      cnt_d      = push ? '0 : push_bytes;
      overflow_d = overflow_q | (push && !wr_en);
      if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (wr_en && !pop)      count_d = count_q + WcW'(1);
      else if (!wr_en && pop) count_d = count_q - WcW'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      asm_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care while empty since the outputs are gated.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_data_q[wr_ptr_q]  <= asm_word;
      mem_bytes_q[wr_ptr_q] <= push_bytes;
    end
  end

  // Show-ahead outputs, forced to zero while empty.
  always_comb begin
    word_valid = (count_q != '0);
    buff_full  = (count_q == WcW'(DEPTH));
    word_count = count_q;
    overflow   = overflow_q;
    rd_data    = word_valid ? mem_data_q[rd_ptr_q] : '0;
    rd_bytes   = word_valid ? mem_bytes_q[rd_ptr_q] : '0;
  end

endmodule

// File: tb/tb_usb_rx_word_fifo.sv
// Bench for usb_rx_word_fifo: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_usb_rx_word_fifo;

  localparam int unsigned Bpw   = 4;
  localparam int unsigned Depth = 4;
  localparam int unsigned DataW = 8 * Bpw;
`ifdef USB_RX_BYTE_SWAP_EN
  localparam bit Swap = 1'b1;
`else
  localparam bit Swap = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             byte_received = 1'b0;
  logic             data_en = 1'b0;
  logic [7:0]       data = 8'h00;
  logic             eop = 1'b0;
  logic             buff_clear = 1'b0;
  logic             rd_en = 1'b0;
  logic [DataW-1:0] rd_data;
  logic [2:0]       rd_bytes;
  logic             word_valid;
  logic             buff_full;
  logic [2:0]       word_count;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  usb_rx_word_fifo #(.BYTES_PER_WORD(Bpw), .DEPTH(Depth)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .byte_received(byte_received),
    .data_en      (data_en),
    .data         (data),
    .eop          (eop),
    .buff_clear   (buff_clear),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_bytes     (rd_bytes),
    .word_valid   (word_valid),
    .buff_full    (buff_full),
    .word_count   (word_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectations are written little-endian; byte-reverse them for the swapped build.
  function automatic logic [31:0] lit(input logic [31:0] le);
    return Swap ? {le[7:0], le[15:8], le[23:16], le[31:24]} : le;
  endfunction

  // Reference model: list of held bytes plus a queue of {word, byte count}.
  logic [7:0]       m_b [Bpw];
  int               m_cnt = 0;
  logic [DataW-1:0] q_data [$];
  int               q_bytes [$];
  bit               m_ovf = 1'b0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst || buff_clear) begin
      m_cnt = 0;
      q_data.delete();
      q_bytes.delete();
      m_ovf = 1'b0;
    end else begin
      int n;
      int occ;
      bit do_push;
      bit do_pop;
      logic [DataW-1:0] w;
      n = m_cnt;
      if (byte_received && data_en) begin
        m_b[n] = data;
        n++;
      end
      do_push = (n == int'(Bpw)) || (eop && n > 0);
      do_pop  = rd_en && q_data.size() > 0;
      occ     = q_data.size();
      w = '0;
      for (int k = 0; k < n; k++) begin
        int pos;
        pos = Swap ? int'(Bpw) - 1 - k : k;
        w = w | (DataW'(m_b[k]) << (8 * pos));
      end
      if (do_pop) begin
        void'(q_data.pop_front());
        void'(q_bytes.pop_front());
      end
      if (do_push) begin
        if (occ < int'(Depth) || do_pop) begin
          q_data.push_back(w);
          q_bytes.push_back(n);
        end else begin
          m_ovf = 1'b1;
        end
        m_cnt = 0;
      end else begin
        m_cnt = n;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int sz;
    sz = q_data.size();
    check("rd_data",    64'(rd_data),    sz > 0 ? 64'(q_data[0]) : 64'd0);
    check("rd_bytes",   64'(rd_bytes),   sz > 0 ? 64'(q_bytes[0]) : 64'd0);
    check("word_valid", 64'(word_valid), 64'(sz > 0));
    check("buff_full",  64'(buff_full),  64'(sz == int'(Depth)));
    check("word_count", 64'(word_count), 64'(sz));
    check("overflow",   64'(overflow),   64'(m_ovf));
  end

  task automatic cyc(input logic br, input logic de, input logic [7:0] d, input logic e,
                     input logic clr, input logic rd);
    byte_received = br;
    data_en       = de;
    data          = d;
    eop           = e;
    buff_clear    = clr;
    rd_en         = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put_byte(input logic [7:0] d);
    cyc(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_word(input logic [7:0] base);
    for (int b = 0; b < int'(Bpw); b++) put_byte(base + 8'(b));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    check("reset_count", 64'(word_count), 64'd0);
    check("reset_data", 64'(rd_data), 64'd0);
    n_rst = 1'b1;
    idle();

    // 1: full word, with an unqualified byte in the middle that must be ignored
    put_byte(8'h11);
    put_byte(8'h22);
    cyc(1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0);
    put_byte(8'h33);
    put_byte(8'h44);
    check("s1_data", 64'(rd_data), 64'(lit(32'h44332211)));
    check("s1_bytes", 64'(rd_bytes), 64'd4);
    check("s1_count", 64'(word_count), 64'd1);
    drain(1);

    // 2: partial flushes on eop
    put_byte(8'hAA);
    put_byte(8'hBB);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("s2_data2", 64'(rd_data), 64'(lit(32'h0000BBAA)));
    check("s2_bytes2", 64'(rd_bytes), 64'd2);
    drain(1);
    put_byte(8'hAA);
    put_byte(8'hBB);
    cyc(1'b1, 1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    check("s2_data3", 64'(rd_data), 64'(lit(32'h00CCBBAA)));
    check("s2_bytes3", 64'(rd_bytes), 64'd3);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);  // eop on empty assembler: no push
    check("s2_empty_eop", 64'(word_count), 64'd0);

    // 3: overflow, then pop-while-full rescue
    push_word(8'h10);
    push_word(8'h20);
    push_word(8'h30);
    push_word(8'h40);
    check("s3_full", 64'(buff_full), 64'd1);
    push_word(8'h50);
    check("s3_ovf", 64'(overflow), 64'd1);
    check("s3_count", 64'(word_count), 64'd4);
    check("s3_head", 64'(rd_data), 64'(lit(32'h13121110)));
    drain(4);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("s3_clr_ovf", 64'(overflow), 64'd0);
    push_word(8'h20);
    push_word(8'h30);
    push_word(8'h40);
    push_word(8'h50);
    put_byte(8'h60);
    put_byte(8'h61);
    put_byte(8'h62);
    cyc(1'b1, 1'b1, 8'h63, 1'b0, 1'b0, 1'b1);
    check("s3_ovf_rescued", 64'(overflow), 64'd0);
    check("s3_count2", 64'(word_count), 64'd4);
    drain(3);
    check("s3_last", 64'(rd_data), 64'(lit(32'h63626160)));
    drain(1);

    // 4: read while empty, then interleaved traffic across pointer wraps
    drain(1);
    check("s4_count", 64'(word_count), 64'd0);
    check("s4_bytes", 64'(rd_bytes), 64'd0);
    for (int i = 0; i < 20; i++) begin
      for (int b = 0; b < int'(Bpw); b++) begin
        cyc(1'b1, 1'b1, 8'(i * 4 + b), 1'b0, 1'b0, 1'(b % 2));
      end
    end
    drain(12);
    check("s4_end_count", 64'(word_count), 64'd0);

    // 5: clear with queued words, a held byte, and colliding accept/read
    push_word(8'h10);
    push_word(8'h20);
    push_word(8'h30);
    push_word(8'h40);
    push_word(8'h50);
    drain(2);
    put_byte(8'hEE);
    cyc(1'b1, 1'b1, 8'hEF, 1'b0, 1'b1, 1'b1);
    check("s5_count", 64'(word_count), 64'd0);
    check("s5_ovf", 64'(overflow), 64'd0);
    push_word(8'h70);
    check("s5_word", 64'(rd_data), 64'(lit(32'h73727170)));
    drain(1);

    // 6: asynchronous reset mid-word
    push_word(8'h80);
    put_byte(8'h90);
    put_byte(8'h91);
    #2 n_rst = 1'b0;
    #1;
    check("s6_data", 64'(rd_data), 64'd0);
    check("s6_valid", 64'(word_valid), 64'd0);
    check("s6_count", 64'(word_count), 64'd0);
    check("s6_bytes", 64'(rd_bytes), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    push_word(8'hA0);
    check("s6_word", 64'(rd_data), 64'(lit(32'hA3A2A1A0)));
    check("s6_wbytes", 64'(rd_bytes), 64'd4);
    check("s6_wcount", 64'(word_count), 64'd1);
    drain(1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
